// File: rtl/nnrv_reg_wb.sv
// nnrv_reg_wb: integer register-file write-back controller and scoreboard.
// Ports:
//   i_clk / i_rst_n                 clock, asynchronous active-low reset
//   i_alu_valid/_rd/_data           single-cycle ALU result, never stalled
//   i_ld_valid/o_ld_ready/_rd/_data handshaked load / multi-cycle result stream
//   i_rsv_en/i_rsv_rd               destination reservation from issue
//   i_q1/i_q2 -> o_q1/o_q2_busy     scoreboard queries for rs1/rs2
//   o_w_en/o_w/o_w_reg              register file write port (registered)
//   o_waw_err                       pulse on reservation of an already-pending rd
//   o_idle                          nothing pending, nothing buffered, no write

// nnrv_reg_wb_fifo: small generic synchronous FIFO with registered occupancy.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: o_full comes from the registered count only; pushes while full are dropped.
module nnrv_reg_wb_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_push_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_head_dat,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic          push_ok;
  logic          pop_ok;

  assign o_full     = (cnt_q == FULL_CNT);
  assign o_empty    = (cnt_q == '0);
  assign o_head_dat = mem_q[rd_ptr_q];
  assign push_ok    = i_push && !o_full;
  assign pop_ok     = i_pop && !o_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = i_push_dat;
      // Power-of-two depth: natural pointer overflow is the modulo wrap.
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// nnrv_reg_wb: merges ALU results and buffered load results onto one write port.
// Latency: selected result appears on o_w_en/o_w/o_w_reg one cycle after selection.
// Backpressure: ALU never stalls and has priority; loads are held off via o_ld_ready.
module nnrv_reg_wb #(
  parameter int XLEN     = 32,
  parameter int REG_NUM  = 32,
  parameter int LD_DEPTH = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_alu_valid,
  input  logic [$clog2(REG_NUM)-1:0] i_alu_rd,
  input  logic [XLEN-1:0]            i_alu_data,
  input  logic                       i_ld_valid,
  output logic                       o_ld_ready,
  input  logic [$clog2(REG_NUM)-1:0] i_ld_rd,
  input  logic [XLEN-1:0]            i_ld_data,
  input  logic                       i_rsv_en,
  input  logic [$clog2(REG_NUM)-1:0] i_rsv_rd,
  input  logic [$clog2(REG_NUM)-1:0] i_q1,
  input  logic [$clog2(REG_NUM)-1:0] i_q2,
  output logic                       o_q1_busy,
  output logic                       o_q2_busy,
  output logic                       o_w_en,
  output logic [$clog2(REG_NUM)-1:0] o_w,
  output logic [XLEN-1:0]            o_w_reg,
  output logic                       o_waw_err,
  output logic                       o_idle
);

  localparam int IDX_W = $clog2(REG_NUM);

  typedef struct packed {
    logic [IDX_W-1:0] rd;
    logic [XLEN-1:0]  dat;
  } ld_ent_t;

  ld_ent_t ld_push_ent;
  ld_ent_t ld_head_ent;
  logic    ld_full;
  logic    ld_empty;
  logic    ld_pop;

  logic               alu_sel;
  logic               sel_vld;
  logic [IDX_W-1:0]   sel_rd;
  logic [XLEN-1:0]    sel_dat;
  logic               rsv_ok;
  logic               clr_hit;

  logic               w_en_q, w_en_d;
  logic [IDX_W-1:0]   w_q, w_d;
  logic [XLEN-1:0]    w_reg_q, w_reg_d;
  logic               waw_err_q, waw_err_d;
  logic [REG_NUM-1:0] pending_q, pending_d;

  // ---------------------------------------------------------------------------
  // Load result buffer
  // ---------------------------------------------------------------------------
  assign ld_push_ent = '{rd: i_ld_rd, dat: i_ld_data};

  nnrv_reg_wb_fifo #(
    .W     ($bits(ld_ent_t)),
    .DEPTH (LD_DEPTH)
  ) u_ld_fifo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_push     (i_ld_valid),
    .i_push_dat (ld_push_ent),
    .i_pop      (ld_pop),
    .o_head_dat (ld_head_ent),
    .o_full     (ld_full),
    .o_empty    (ld_empty)
  );

  // Ready depends only on the registered occupancy, so a full FIFO never
  // accepts a push even when it is being drained in the same cycle.
  assign o_ld_ready = !ld_full;

  // ---------------------------------------------------------------------------
  // Arbitration and write port
  // ---------------------------------------------------------------------------
  always_comb begin
    // An x0 ALU result is dropped and leaves the slot free for the FIFO.
    alu_sel = i_alu_valid && (i_alu_rd != '0);
    // The head is popped whenever the ALU does not claim the port; an x0
    // head is consumed without producing a write.
    ld_pop  = !alu_sel && !ld_empty;
    sel_vld = alu_sel || (ld_pop && (ld_head_ent.rd != '0));
    sel_rd  = alu_sel ? i_alu_rd   : ld_head_ent.rd;
    sel_dat = alu_sel ? i_alu_data : ld_head_ent.dat;

    w_en_d  = sel_vld;
    w_d     = sel_vld ? sel_rd  : w_q;
    w_reg_d = sel_vld ? sel_dat : w_reg_q;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  always_comb begin
    rsv_ok  = i_rsv_en && (i_rsv_rd != '0);
    // The register file captures the write at the end of the o_w_en cycle,
    // so that is the edge where the pending bit is released.
    clr_hit = w_en_q && (w_q == i_rsv_rd);

    pending_d = pending_q;
    if (w_en_q) begin
      pending_d[w_q] = 1'b0;
    end
    // Applied after the clear so a same-edge reservation claims the bit.
    if (rsv_ok) begin
      pending_d[i_rsv_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;

    waw_err_d = rsv_ok && pending_q[i_rsv_rd] && !clr_hit;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      w_en_q    <= 1'b0;
      w_q       <= '0;
      w_reg_q   <= '0;
      waw_err_q <= 1'b0;
      pending_q <= '0;
    end else begin
      w_en_q    <= w_en_d;
      w_q       <= w_d;
      w_reg_q   <= w_reg_d;
      waw_err_q <= waw_err_d;
      pending_q <= pending_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_w_en    = w_en_q;
  assign o_w       = w_q;
  assign o_w_reg   = w_reg_q;
  assign o_waw_err = waw_err_q;
  assign o_q1_busy = pending_q[i_q1];
  assign o_q2_busy = pending_q[i_q2];
  assign o_idle    = (pending_q == '0) && ld_empty && !w_en_q;

endmodule
